playlist_sequencer: RTL and testbench

- Sequences the song reader across a playlist of NUM_SONGS songs.
- Turns single-cycle user button pulses (play/pause, next, prev) into the reader's play level and song select.
- Restarts the reader's note counter on every song change by pulsing reader_rst, and inserts a beat-counted silent gap between automatically advanced songs.
- Sits between the button debouncers/beat generator and the song reader.

---
 rtl/playlist_sequencer.sv | 167 ++++++++++++++++
 tb/tb_playlist_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/playlist_sequencer.sv
// playlist_sequencer: steps the song reader through a playlist of NUM_SONGS songs.
// Turns play/next/prev button pulses into the reader's play level and song select.
// On every song change it pulses reader_rst for FLUSH_CYCLES cycles.
// Between auto-advanced songs it inserts a silent gap of GAP_BEATS beats.
// Optional feature macro: PLAYLIST_LOOP_EN. When it is defined, the sequencer
// wraps from the last song back to song 0 and keeps playing. When it is not
// defined, it stops in IDLE after the last song.
module playlist_sequencer #(
  parameter int NUM_SONGS    = 4,
  parameter int SONG_BITS    = 2,
  parameter int GAP_BEATS    = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play_btn,
  input  logic                 next_btn,
  input  logic                 prev_btn,
  input  logic                 song_done,
  input  logic                 beat,
  output logic                 play,
  output logic [SONG_BITS-1:0] song,
  output logic                 reader_rst,
  output logic                 gap_active
);

  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam int GAP_W   = (GAP_BEATS > 0) ? $clog2(GAP_BEATS + 1) : 1;

  localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'((GAP_BEATS > 0) ? GAP_BEATS - 1 : 0);
  localparam logic [SONG_BITS-1:0] SONG_LAST  = SONG_BITS'(NUM_SONGS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAYING = 3'd1,
    PAUSED  = 3'd2,
    FLUSH   = 3'd3,
    GAP     = 3'd4
  } state_t;

  // After an automatic advance, the reader goes to the silent gap, or straight
  // to playback when no gap is configured.
  localparam state_t AUTO_TARGET = (GAP_BEATS > 0) ? GAP : PLAYING;

  state_t               state, state_nx;
  state_t               flush_target, flush_target_nx;
  logic [SONG_BITS-1:0] song_nx;
  logic [FLUSH_W-1:0]   flush_cnt, flush_cnt_nx;
  logic [GAP_W-1:0]     gap_cnt, gap_cnt_nx;

  function automatic logic [SONG_BITS-1:0] song_inc(input logic [SONG_BITS-1:0] s);
    return (s == SONG_LAST) ? '0 : s + SONG_BITS'(1);
  endfunction

  function automatic logic [SONG_BITS-1:0] song_dec(input logic [SONG_BITS-1:0] s);
    return (s == '0) ? SONG_LAST : s - SONG_BITS'(1);
  endfunction

  // State, song and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!reset) begin
      state        <= IDLE;
      song         <= '0;
      flush_target <= IDLE;
      flush_cnt    <= '0;
      gap_cnt      <= '0;
    end else begin
      state        <= state_nx;
      song         <= song_nx;
      flush_target <= flush_target_nx;
      flush_cnt    <= flush_cnt_nx;
      gap_cnt      <= gap_cnt_nx;
    end
  end

  // Next-state logic: next > prev > play; song_done wins in PLAYING; FLUSH ignores buttons.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_nx        = state;
    song_nx         = song;
    flush_target_nx = flush_target;
    flush_cnt_nx    = '0;
    gap_cnt_nx      = '0;

    unique case (state)
      IDLE, PAUSED: begin
        if (next_btn) begin
          song_nx         = song_inc(song);
          state_nx        = FLUSH;
          flush_target_nx = PAUSED;
        end else if (prev_btn) begin
          song_nx         = song_dec(song);
          state_nx        = FLUSH;
          flush_target_nx = PAUSED;
        end else if (play_btn) begin
          state_nx = PLAYING;
        end
      end

      PLAYING: begin
        if (song_done) begin
          state_nx = FLUSH;
          if (song != SONG_LAST) begin
            song_nx         = song + SONG_BITS'(1);
            flush_target_nx = AUTO_TARGET;
          end else begin
            song_nx = '0;
`ifdef PLAYLIST_LOOP_EN
            flush_target_nx = AUTO_TARGET;
`else
            flush_target_nx = IDLE;
`endif
          end
        end else if (next_btn) begin
          song_nx         = song_inc(song);
          state_nx        = FLUSH;
          flush_target_nx = PLAYING;
        end else if (prev_btn) begin
          song_nx         = song_dec(song);
          state_nx        = FLUSH;
          flush_target_nx = PLAYING;
        end else if (play_btn) begin
          state_nx = PAUSED;
        end
      end

      FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_nx = flush_target;
        end else begin
          flush_cnt_nx = flush_cnt + FLUSH_W'(1);
        end
      end

      GAP: begin
        gap_cnt_nx = gap_cnt;
        if (next_btn) begin
          song_nx         = song_inc(song);
          state_nx        = FLUSH;
          flush_target_nx = PLAYING;
        end else if (prev_btn) begin
          song_nx         = song_dec(song);
          state_nx        = FLUSH;
          flush_target_nx = PLAYING;
        end else if (play_btn) begin
          state_nx = PAUSED;
        end else if (beat) begin
          if (gap_cnt == GAP_LAST) begin
            state_nx = PLAYING;
          end else begin
            gap_cnt_nx = gap_cnt + GAP_W'(1);
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // The outputs are decoded from registered state only.
  assign play       = (state == PLAYING);
  assign reader_rst = (state == FLUSH);
  assign gap_active = (state == GAP);

endmodule

// File: tb/tb_playlist_sequencer.sv
// Self-checking bench for playlist_sequencer. A behavioural playlist model
// tracks the mode, song index (modulo arithmetic), the remaining flush cycles
// and the beats heard, and it is compared with the DUT after every clock.
module tb_playlist_sequencer;

  localparam int NUM_SONGS    = 4;
  localparam int SONG_BITS    = 2;
  localparam int GAP_BEATS    = 8;
  localparam int FLUSH_CYCLES = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 play_btn, next_btn, prev_btn, song_done, beat;
  logic                 play, reader_rst, gap_active;
  logic [SONG_BITS-1:0] song;

  playlist_sequencer #(
    .NUM_SONGS(NUM_SONGS), .SONG_BITS(SONG_BITS),
    .GAP_BEATS(GAP_BEATS), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .play_btn(play_btn), .next_btn(next_btn),
    .prev_btn(prev_btn), .song_done(song_done), .beat(beat), .play(play),
    .song(song), .reader_rst(reader_rst), .gap_active(gap_active)
  );

  always #5 clk = ~clk;

  typedef enum int { M_IDLE, M_PLAY, M_PAUSE, M_FLUSH, M_GAP } mode_t;

  mode_t m_mode, m_target;
  int    m_song, m_flush_left, m_beats;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, actual, expected);
    end
  endtask

  function automatic void enter_flush(input mode_t target);
    m_mode       = M_FLUSH;
    m_flush_left = FLUSH_CYCLES;
    m_target     = target;
  endfunction

  function automatic void model_clock(input bit r, p, n, pv, d, b);
    mode_t auto_t;
    auto_t = (GAP_BEATS == 0) ? M_PLAY : M_GAP;
    if (!r) begin
      m_mode = M_IDLE; m_song = 0; m_flush_left = 0; m_beats = 0;
      return;
    end
    case (m_mode)
      M_FLUSH: begin
        m_flush_left--;
        if (m_flush_left == 0) begin
          m_mode  = m_target;
          m_beats = 0;
        end
      end
      M_PLAY: begin
        if (d) begin
          if (m_song < NUM_SONGS - 1) begin
            m_song++;
            enter_flush(auto_t);
          end else begin
            m_song = 0;
`ifdef PLAYLIST_LOOP_EN
            enter_flush(auto_t);
`else
            enter_flush(M_IDLE);
`endif
          end
        end else if (n) begin
          m_song = (m_song + 1) % NUM_SONGS; enter_flush(M_PLAY);
        end else if (pv) begin
          m_song = (m_song + NUM_SONGS - 1) % NUM_SONGS; enter_flush(M_PLAY);
        end else if (p) m_mode = M_PAUSE;
      end
      M_IDLE, M_PAUSE: begin
        if (n) begin
          m_song = (m_song + 1) % NUM_SONGS; enter_flush(M_PAUSE);
        end else if (pv) begin
          m_song = (m_song + NUM_SONGS - 1) % NUM_SONGS; enter_flush(M_PAUSE);
        end else if (p) m_mode = M_PLAY;
      end
      M_GAP: begin
        if (n) begin
          m_song = (m_song + 1) % NUM_SONGS; enter_flush(M_PLAY);
        end else if (pv) begin
          m_song = (m_song + NUM_SONGS - 1) % NUM_SONGS; enter_flush(M_PLAY);
        end else if (p) m_mode = M_PAUSE;
        else if (b) begin
          m_beats++;
          if (m_beats == GAP_BEATS) m_mode = M_PLAY;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endfunction

  // One clock: drive the inputs, let the edge happen, advance the model, and compare.
  task automatic step(input bit r, p, n, pv, d, b);
    reset = r; play_btn = p; next_btn = n; prev_btn = pv; song_done = d; beat = b;
    @(posedge clk);
    model_clock(r, p, n, pv, d, b);
    #1;
    check("play",       int'(play),       int'(m_mode == M_PLAY));
    check("song",       int'(song),       m_song);
    check("reader_rst", int'(reader_rst), int'(m_mode == M_FLUSH));
    check("gap_active", int'(gap_active), int'(m_mode == M_GAP));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 0; play_btn = 0; next_btn = 0; prev_btn = 0; song_done = 0; beat = 0;
    m_mode = M_IDLE; m_target = M_IDLE; m_song = 0; m_flush_left = 0; m_beats = 0;

    // Reset state.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("rst_play", int'(play), 0);
    check("rst_song", int'(song), 0);
    check("rst_rrst", int'(reader_rst), 0);
    idle(1);

    // The play button starts playback on the next cycle.
    step(1, 1, 0, 0, 0, 0);
    check("play_start", int'(play), 1);

    // Manual skip from song 0 to song 1, then from song 1 to song 2 with exactly two flush cycles.
    step(1, 0, 1, 0, 0, 0); idle(2);
    check("at_song1", int'(song), 1);
    step(1, 0, 1, 0, 0, 0);
    check("skip_song", int'(song), 2);
    check("skip_rrst1", int'(reader_rst), 1);
    check("skip_play0", int'(play), 0);
    idle(1);
    check("skip_rrst2", int'(reader_rst), 1);
    idle(1);
    check("skip_resume", int'(play), 1);
    check("skip_nogap", int'(gap_active), 0);

    // Go back to song 0, auto-advance into the gap, then reset after 3 beats.
    step(1, 0, 0, 1, 0, 0); idle(2);
    step(1, 0, 0, 1, 0, 0); idle(2);
    check("at_song0", int'(song), 0);
    step(1, 0, 0, 0, 1, 0); idle(2);
    check("gap_entered", int'(gap_active), 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check("gaprst_gap", int'(gap_active), 0);
    check("gaprst_song", int'(song), 0);
    check("gaprst_play", int'(play), 0);

    // A fresh auto-advance counts the full gap starting from zero.
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 0); idle(2);
    for (int i = 0; i < GAP_BEATS; i++) begin
      check("gap_hold", int'(gap_active), 1);
      idle(2);
      step(1, 0, 0, 0, 0, 1);
    end
    check("gap_exit", int'(play), 1);

    // Last song: skip to song 3 and finish it.
    step(1, 0, 1, 0, 0, 0); idle(2);
    step(1, 0, 1, 0, 0, 0); idle(2);
    check("at_song3", int'(song), 3);
    step(1, 0, 0, 0, 1, 0);
    check("last_wrap", int'(song), 0);
    idle(2);
`ifdef PLAYLIST_LOOP_EN
    check("last_loop_gap", int'(gap_active), 1);
    step(0, 0, 0, 0, 0, 0);
`else
    check("last_stop_play", int'(play), 0);
`endif
    idle(3);

    // In IDLE on song 0, prev wraps to song 3 and lands in PAUSED; then a coincident press lets only next act.
    step(1, 0, 0, 1, 0, 0);
    check("prev_wrap", int'(song), 3);
    idle(2);
    step(1, 1, 1, 1, 0, 0);
    check("prio_next", int'(song), 0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
